// File: rtl/reverb_comb_delay_if.sv
// ---------------------------------------------------------------------------
// reverb_comb_delay_if
// Purpose : groups the sample handshake and control signals of the
//           feedback-comb reverb stage into a single bundle.
// Signals :
//   Enable       1         1: out carries the reverb result, 0: dry bypass
//   sample_valid 1         one-cycle strobe, in is valid
//   in           DATA_W    input sample (signed)
//   feedback     COEF_W    loop gain, signed Q1.(COEF_W-1)
//   looptime     ADDR_W+1  requested loop length in samples
//   damp         COEF_W    lowpass coefficient (only with REVERB_DAMPING_EN)
//   ready        1         stage accepts a strobe this cycle
//   out          DATA_W    output sample, held between strobes
//   out_valid    1         one-cycle strobe, out updated
//   overrun      1         sticky, a strobe arrived while ready was low
// Modports: master drives samples into the stage, slave is the stage itself.
// Optional feature macro: REVERB_DAMPING_EN adds the damp signal.
// ---------------------------------------------------------------------------
interface reverb_comb_delay_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 10
);
    logic              Enable;
    logic              sample_valid;
    logic [DATA_W-1:0] in;
    logic [COEF_W-1:0] feedback;
    logic [ADDR_W:0]   looptime;
`ifdef REVERB_DAMPING_EN
    logic [COEF_W-1:0] damp;
`endif
    logic              ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              overrun;

`ifdef REVERB_DAMPING_EN
    modport master (
        output Enable, sample_valid, in, feedback, looptime, damp,
        input  ready, out, out_valid, overrun
    );
    modport slave (
        input  Enable, sample_valid, in, feedback, looptime, damp,
        output ready, out, out_valid, overrun
    );
`else
    modport master (
        output Enable, sample_valid, in, feedback, looptime,
        input  ready, out, out_valid, overrun
    );
    modport slave (
        input  Enable, sample_valid, in, feedback, looptime,
        output ready, out, out_valid, overrun
    );
`endif
endinterface

// File: rtl/reverb_comb_delay.sv
// ---------------------------------------------------------------------------
// reverb_comb_delay
// Purpose : feedback-comb reverb stage between voice mixer and DAC driver.
//           y[n] = sat((x[n] + d[n]) * g), y is written back into a delay
//           line held in on-chip RAM, and d[n] = y[n-L].
//           The line is cleared after every reset, the loop length can be
//           changed at run time (takes effect at the next wrap), and a
//           strobe that arrives while busy sets a sticky overrun flag.
// Ports   :
//   Clk    in  system clock
//   Reset  in  synchronous, active-high reset
//   bus    slave side of reverb_comb_delay_if (handshake, samples, controls)
// Latency : strobe sampled on clock edge k -> out/out_valid updated on edge
//           k+2 (k+3 with damping); the stage is ready again right after.
// Optional feature macro: REVERB_DAMPING_EN inserts a one-pole lowpass
//           (DAMP state) in the loop, controlled by bus.damp.
// ---------------------------------------------------------------------------
module reverb_comb_delay #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int MAX_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(MAX_DEPTH)
) (
    input logic                Clk,
    input logic                Reset,
    reverb_comb_delay_if.slave bus
);
    localparam int SUM_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_DAMP
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [MAX_DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] in_lat;
    logic [COEF_W-1:0] fb_lat;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] clr_cnt;
    logic [LEN_W-1:0]  active_len;
    logic [LEN_W-1:0]  loop_len;
    logic              ptr_last;
    logic              ready_c;
    logic              accept;
    logic              commit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [SUM_W-1:0]         sum;
    logic [PROD_W-1:0]        sum_ext;
    logic [PROD_W-1:0]        fb_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic [DATA_W-1:0]        y_c;
    logic [DATA_W-1:0]        result;

    // Clamp a wide signed value into the sample range. If every bit above
    // the sample's sign bit agrees with it, the value already fits;
    // otherwise it pins to the rail on the side of the true sign.
    function automatic logic [DATA_W-1:0] sat_data(input logic [PROD_W-1:0] v);
        logic [PROD_W-DATA_W:0] top;
        top = v[PROD_W-1:DATA_W-1];
        if ((~|top) || (&top)) begin
            sat_data = v[DATA_W-1:0];
        end else if (v[PROD_W-1]) begin
            sat_data = SAT_MIN;
        end else begin
            sat_data = SAT_MAX;
        end
    endfunction

    // State register. Reset always sends the stage back to clearing the
    // delay line, which also discards any sample still in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. accept marks a strobe taken in IDLE,
    // commit marks the single cycle in which the finished sample is written
    // back, presented on out, and the pointer advances.
    always_comb begin
        next_state = state;
        ready_c    = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == ADDR_W'(MAX_DEPTH - 1)) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.sample_valid) begin
                    accept     = 1'b1;
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                next_state = ST_CALC;
            end
            ST_CALC: begin
`ifdef REVERB_DAMPING_EN
                next_state = ST_DAMP;
`else
                commit     = 1'b1;
                next_state = ST_IDLE;
`endif
            end
            ST_DAMP: begin
`ifdef REVERB_DAMPING_EN
                commit     = 1'b1;
`endif
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_CLEAR;
            end
        endcase
    end

    assign bus.ready = ready_c;

    // Effective loop length: 0 behaves as 1 and anything longer than the
    // RAM is limited to the RAM depth, so the pointer can never leave the
    // line. ptr_last flags the entry after which the pointer wraps.
    always_comb begin
        if (active_len == '0) begin
            loop_len = LEN_W'(1);
        end else if (active_len > LEN_W'(MAX_DEPTH)) begin
            loop_len = LEN_W'(MAX_DEPTH);
        end else begin
            loop_len = active_len;
        end
        ptr_last = ({1'b0, wr_ptr} == (loop_len - LEN_W'(1)));
    end

    // Comb arithmetic: one extra bit for the sum so it cannot overflow,
    // both operands sign-extended to the full product width, then the
    // Q1.(COEF_W-1) scaling shift and saturation back to sample width.
    always_comb begin
        sum     = {in_lat[DATA_W-1], in_lat} + {rd_data[DATA_W-1], rd_data};
        sum_ext = {{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum};
        fb_ext  = {{(PROD_W-COEF_W){fb_lat[COEF_W-1]}}, fb_lat};
        prod    = $signed(sum_ext) * $signed(fb_ext);
        shifted = prod >>> (COEF_W - 1);
        y_c     = sat_data(shifted);
    end

`ifdef REVERB_DAMPING_EN
    logic [DATA_W-1:0]        y_reg;
    logic [DATA_W-1:0]        lp;
    logic [COEF_W-1:0]        damp_lat;
    logic [SUM_W-1:0]         diff;
    logic [PROD_W-1:0]        diff_ext;
    logic [PROD_W-1:0]        damp_ext;
    logic signed [PROD_W-1:0] dprod;
    logic signed [PROD_W-1:0] dshift;
    logic [DATA_W-1:0]        dstep;
    logic [SUM_W-1:0]         lp_sum;
    logic [DATA_W-1:0]        lp_next;

    // One-pole lowpass step: move lp toward the comb result by a fraction
    // damp of the distance. The final clamp is only a guard; with damp in
    // 0..1 the new lp lies between the old lp and y.
    always_comb begin
        diff     = {y_reg[DATA_W-1], y_reg} - {lp[DATA_W-1], lp};
        diff_ext = {{(PROD_W-SUM_W){diff[SUM_W-1]}}, diff};
        damp_ext = {{(PROD_W-COEF_W){damp_lat[COEF_W-1]}}, damp_lat};
        dprod    = $signed(diff_ext) * $signed(damp_ext);
        dshift   = dprod >>> (COEF_W - 1);
        dstep    = sat_data(dshift);
        lp_sum   = {lp[DATA_W-1], lp} + {dstep[DATA_W-1], dstep};
        lp_next  = sat_data({{(PROD_W-SUM_W){lp_sum[SUM_W-1]}}, lp_sum});
    end

    // Damping registers: the comb result is captured in CALC, and the
    // filter state advances only when a sample is committed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            y_reg    <= '0;
            lp       <= '0;
            damp_lat <= '0;
        end else begin
            if (accept) begin
                damp_lat <= bus.damp;
            end
            if (state == ST_CALC) begin
                y_reg <= y_c;
            end
            if (commit) begin
                lp <= lp_next;
            end
        end
    end

    assign result = lp_next;
`else
    assign result = y_c;
`endif

    // Single RAM write port shared between the power-on clear sweep and
    // the sample write-back; the line is written with the loop value even
    // when the output is bypassed.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_ptr;
        mem_wdata = result;
        if (!Reset) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = '0;
            end else if (commit) begin
                mem_we = 1'b1;
            end
        end
    end

    // Delay-line RAM with a registered read. No reset here so the array
    // maps onto block RAM; the clear sweep provides the known contents.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (state == ST_READ) begin
            rd_data <= mem[wr_ptr];
        end
    end

    // Sample path and bookkeeping. active_len only reloads on a wrap so a
    // new loop length never cuts a loop short mid-way. Strobes arriving
    // while busy are ignored apart from raising the sticky overrun flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overrun   <= 1'b0;
            wr_ptr        <= '0;
            clr_cnt       <= '0;
            active_len    <= bus.looptime;
            in_lat        <= '0;
            fb_lat        <= '0;
        end else begin
            bus.out_valid <= commit;
            if (bus.sample_valid && !ready_c) begin
                bus.overrun <= 1'b1;
            end
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
            if (accept) begin
                in_lat <= bus.in;
                fb_lat <= bus.feedback;
            end
            if (commit) begin
                bus.out <= bus.Enable ? result : in_lat;
                if (ptr_last) begin
                    wr_ptr     <= '0;
                    active_len <= bus.looptime;
                end else begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_reverb_comb_delay.sv
// ---------------------------------------------------------------------------
// tb_reverb_comb_delay
// Purpose : self-checking bench for reverb_comb_delay (default build, no
//           damping). Stimulus pushes the expected output of every accepted
//           sample into a queue; a monitor pops and compares whenever the
//           stage raises out_valid.
// ---------------------------------------------------------------------------
module tb_reverb_comb_delay;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int MAX_DEPTH = 1024;
    localparam int ADDR_W    = 10;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] expQ[$];

    // Reference delay line: plain array of past loop values, a position,
    // and the currently active requested loop length.
    int line [MAX_DEPTH];
    int mptr;
    int mlen;

    // Free-running clock, 10 time units per cycle.
    always #5 Clk = ~Clk;

    reverb_comb_delay_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

    reverb_comb_delay #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    // Count one comparison and report it when it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int satData(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int effLen(input int requested);
        if (requested == 0) return 1;
        if (requested > MAX_DEPTH) return MAX_DEPTH;
        return requested;
    endfunction

    task automatic modelReset(input int lt);
        foreach (line[i]) line[i] = 0;
        mptr = 0;
        mlen = lt;
    endtask

    // One comb step with integer arithmetic: x + d, times gain, divided by
    // 2^15 rounding toward minus infinity, clamped to 16 bits.
    task automatic modelStep(input logic [15:0] x, input logic [15:0] fb,
                             input logic [10:0] lt, input logic en,
                             output logic [15:0] e);
        int     xs;
        int     fs;
        int     y;
        int     len;
        longint prod;
        xs   = int'($signed(x));
        fs   = int'($signed(fb));
        len  = effLen(mlen);
        prod = longint'(xs + line[mptr]) * longint'(fs);
        y    = satData(prod >>> (COEF_W - 1));
        line[mptr] = y;
        e = en ? 16'(y) : x;
        if (mptr == len - 1) begin
            mptr = 0;
            mlen = int'(lt);
        end else begin
            mptr++;
        end
    endtask

    // Bounded wait for ready, checked just after a rising edge.
    task automatic waitReady();
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checkOutput("readyTimeout", 32'(bus.ready), 32'd1);
        end
    endtask

    // Issue one accepted sample and record its expected output.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] fb,
                                 input logic [10:0] lt, input logic en);
        logic [15:0] e;
        waitReady();
        bus.in           = x;
        bus.feedback     = fb;
        bus.looptime     = lt;
        bus.Enable       = en;
        bus.sample_valid = 1'b1;
        modelStep(x, fb, lt, en, e);
        expQ.push_back(e);
        @(posedge Clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge Clk);
            if (bus.out_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("outValidWithoutSample", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outSample", 32'(bus.out), 32'(e));
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int ltChoices[7] = '{0, 1, 2, 3, 5, 8, 2000};
        logic [15:0] e;

        bus.sample_valid = 1'b0;
        bus.in           = '0;
        bus.feedback     = '0;
        bus.looptime     = 11'd4;
        bus.Enable       = 1'b1;

        // Reset held long, then the clear sweep must take exactly MAX_DEPTH cycles.
        Reset = 1'b1;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        checkOutput("resetOut", 32'(bus.out), 32'd0);
        checkOutput("resetOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("resetReady", 32'(bus.ready), 32'd0);
        checkOutput("resetOverrun", 32'(bus.overrun), 32'd0);
        repeat (1080) @(posedge Clk);
        #1;
        Reset = 1'b0;
        modelReset(4);
        n = 0;
        @(negedge Clk);
        while (bus.ready === 1'b0 && n < 2000) begin
            n++;
            @(negedge Clk);
        end
        checkOutput("clearCycles", 32'(n), 32'd1024);
        checkOutput("postClearOut", 32'(bus.out), 32'd0);
        checkOutput("postClearOverrun", 32'(bus.overrun), 32'd0);
        @(posedge Clk);
        #1;

        $display("[TB] impulse, L=4, g=0.5");
        applyStimulus(16'h4000, 16'h4000, 11'd4, 1'b1);
        repeat (11) applyStimulus(16'h0000, 16'h4000, 11'd4, 1'b1);

        $display("[TB] saturation, L=1, g=max");
        repeat (4) applyStimulus(16'h7FFF, 16'h7FFF, 11'd1, 1'b1);
        repeat (4) applyStimulus(16'h8000, 16'h7FFF, 11'd1, 1'b1);

        $display("[TB] loop length change mid-loop 4 -> 2");
        repeat (4) applyStimulus(16'h0000, 16'h0000, 11'd4, 1'b1);
        applyStimulus(16'h4000, 16'h4000, 11'd4, 1'b1);
        applyStimulus(16'h0000, 16'h4000, 11'd4, 1'b1);
        repeat (10) applyStimulus(16'h0000, 16'h4000, 11'd2, 1'b1);

        $display("[TB] bypass then re-enable");
        applyStimulus(16'h1234, 16'h4000, 11'd2, 1'b0);
        applyStimulus(16'h0000, 16'h4000, 11'd2, 1'b0);
        repeat (6) applyStimulus(16'h0000, 16'h4000, 11'd2, 1'b1);

        $display("[TB] randomized samples");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(16'($urandom), 16'($urandom),
                          11'(ltChoices[$urandom_range(0, 6)]), 1'($urandom_range(0, 1)));
        end

        $display("[TB] back-to-back strobes");
        waitReady();
        bus.in           = 16'h0100;
        bus.feedback     = 16'h6000;
        bus.Enable       = 1'b1;
        bus.sample_valid = 1'b1;
        modelStep(bus.in, bus.feedback, bus.looptime, 1'b1, e);
        expQ.push_back(e);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        bus.sample_valid = 1'b0;
        @(negedge Clk);
        checkOutput("overrunSet", 32'(bus.overrun), 32'd1);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        checkOutput("overrunSticky", 32'(bus.overrun), 32'd1);
        @(posedge Clk);
        #1;

        $display("[TB] reset with a sample in flight");
        waitReady();
        bus.in           = 16'h4000;
        bus.feedback     = 16'h4000;
        bus.sample_valid = 1'b1;
        @(posedge Clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.looptime     = 11'd3;
        Reset            = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            checkOutput("resetNoOutValid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        modelReset(3);
        @(negedge Clk);
        checkOutput("reresetOut", 32'(bus.out), 32'd0);
        checkOutput("reresetOverrun", 32'(bus.overrun), 32'd0);
        checkOutput("reresetReady", 32'(bus.ready), 32'd0);
        @(posedge Clk);
        #1;
        applyStimulus(16'h4000, 16'h4000, 11'd3, 1'b1);
        repeat (6) applyStimulus(16'h0000, 16'h4000, 11'd3, 1'b1);

        repeat (10) @(posedge Clk);
        @(negedge Clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
